// File: rtl/dcl_pkg.sv
// Shared types, reset defaults and the final-value helper for the dual counter loop.
package dcl_pkg;

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} dcl_state_e;

  localparam int DCL_W       = 11;
  localparam int DCL_X_LIMIT = 200;
  localparam int DCL_X_KNEE  = 100;
  localparam int DCL_Y_INIT  = 100;

  // Expected y at the end of an unsaturated run: y_init plus one per step past the knee.
  // Arguments are zero-extended to 32 bits by the caller; the 33-bit result never wraps.
  function automatic logic [32:0] dcl_final_y(input logic [31:0] y_init,
                                              input logic [31:0] limit,
                                              input logic [31:0] knee);
    logic [32:0] span;
    span = (limit > knee) ? {1'b0, limit - knee} : 33'd0;
    return {1'b0, y_init} + span;
  endfunction

endpackage

// File: rtl/dcl_step.sv
// Combinational step datapath: next x, next y and saturation flag for one enabled RUN cycle.
module dcl_step #(
  parameter int W = 11
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] knee,
  input  logic [W-1:0] limit,
  output logic [W-1:0] x_nxt,
  output logic [W-1:0] y_nxt,
  output logic         sat_set,
  output logic         can_step,
  output logic         last
);
  import dcl_pkg::*;

  logic [W:0] x_p1;
  logic       inc_due;
  logic       y_max;

  // Knee and limit compares run one bit wider so x+1 never wraps into a false match.
  always_comb begin
    x_p1     = {1'b0, x} + (W+1)'(1);
    inc_due  = x_p1 > {1'b0, knee};
    y_max    = &y;
    can_step = x < limit;
    last     = x_p1 == {1'b0, limit};
    x_nxt    = x_p1[W-1:0];
    y_nxt    = (inc_due && !y_max) ? y + W'(1) : y;
    sat_set  = inc_due && y_max;
  end

endmodule

// File: rtl/dual_counter_loop_param.sv
// Two-variable bounded counter loop with enable gating, DONE/reload handshake,
// sticky y saturation and a final-value property output.
module dual_counter_loop_param
  import dcl_pkg::*;
#(
  parameter int W       = DCL_W,
  parameter int X_LIMIT = DCL_X_LIMIT,
  parameter int X_KNEE  = DCL_X_KNEE,
  parameter int Y_INIT  = DCL_Y_INIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         selector,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_limit,
  input  logic [W-1:0] cfg_knee,
  input  logic [W-1:0] cfg_y_init,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         done,
  output logic         y_sat,
  output logic         prop_ok
);

  dcl_state_e  state;
  logic [W-1:0] limit_l, knee_l, y_init_l;
  logic [W-1:0] x_nxt, y_nxt;
  logic         sat_set, can_step, last;

  dcl_step #(.W(W)) u_step (
    .x        (x),
    .y        (y),
    .knee     (knee_l),
    .limit    (limit_l),
    .x_nxt    (x_nxt),
    .y_nxt    (y_nxt),
    .sat_set  (sat_set),
    .can_step (can_step),
    .last     (last)
  );

  // Run/done sequencing, counter update and config latching; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      x        <= '0;
      y        <= W'(Y_INIT);
      y_sat    <= 1'b0;
      limit_l  <= W'(X_LIMIT);
      knee_l   <= W'(X_KNEE);
      y_init_l <= W'(Y_INIT);
    end else begin
      case (state)
        RUN: begin
          if (selector) begin
            if (can_step) begin
              x <= x_nxt;
              y <= y_nxt;
              if (sat_set) y_sat <= 1'b1;
              if (last)    state <= DONE;
            end else begin
              // only reachable with a zero limit: finish without touching x or y
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (cfg_valid) begin
            limit_l  <= cfg_limit;
            knee_l   <= cfg_knee;
            y_init_l <= cfg_y_init;
            x        <= '0;
            y        <= cfg_y_init;
            y_sat    <= 1'b0;
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign done      = (state == DONE);
  assign cfg_ready = (state == DONE);
  assign prop_ok   = !done || y_sat ||
                     (33'(y) == dcl_final_y(32'(y_init_l), 32'(limit_l), 32'(knee_l)));

endmodule

// File: doc/dual_counter_loop_param.md
Name: dual_counter_loop_param

Overview:
Parametrised successor to the two-variable bounded counter loop used in our arithmetic property-mining cases.
- x counts from 0 to a run-time limit.
- y starts at a run-time initial value and increments only on steps where x+1 exceeds a run-time knee.
- Adds enable gating, a config/restart handshake, a DONE state, y saturation and a built-in final-value check output (prop_ok) for the formal flow.

Parameters:
W, 11, width of x, y and all config fields
X_LIMIT, 200, default limit after reset (must be < 2^W)
X_KNEE, 100, default knee after reset
Y_INIT, 100, default y start value after reset

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-low reset (rst==0 at posedge resets)
selector  in  1  step enable; 0 freezes x, y and state
cfg_valid  in  1  config/restart request
cfg_ready  out  1  config accepted when cfg_valid&&cfg_ready
cfg_limit  in  W  new limit
cfg_knee  in  W  new knee
cfg_y_init  in  W  new y start value
x  out  W  loop counter
y  out  W  dependent counter
done  out  1  state==DONE
y_sat  out  1  sticky: y saturated during current run
prop_ok  out  1  final-value check (combinational)

Behaviour:
- Reset (rst==0 at posedge), including mid-run:
  - x=0, y=Y_INIT, y_sat=0, state=RUN.
  - Latched limit/knee/y_init = X_LIMIT/X_KNEE/Y_INIT.
  - Reset wins over every other input.
- States: RUN, DONE. Registered state; outputs are registers except cfg_ready, done and prop_ok.
- RUN, selector=1, x<limit (one step per cycle):
  - x<=x+1.
  - If (x+1) > knee, y<=y+1, else y holds. Compare is done in W+1 bits, so no wrap.
  - If y==2^W-1 when an increment is due, y holds and y_sat<=1.
  - If x+1==limit, state<=DONE on the same edge.
- RUN, x>=limit (only possible with limit==0 after a load): state<=DONE next enabled cycle, x and y unchanged.
- RUN, selector=0: everything holds.
- cfg_ready = (state==DONE); it does not depend on selector.
- cfg_valid during RUN is ignored; no queuing.
- DONE, cfg_valid=1:
  - Latch cfg_limit, cfg_knee, cfg_y_init.
  - x<=0, y<=cfg_y_init, y_sat<=0, state<=RUN.
  - Stepping starts the following cycle.
- DONE without cfg_valid: x and y hold indefinitely.
- prop_ok = !done || y_sat || (y == y_init_l + (limit_l > knee_l ? limit_l - knee_l : 0)).
  - The sum is computed in W+1 bits.
  - With defaults this is the invariant "x<200 || y==200".
- No latency beyond one cycle per step. A default run takes exactly X_LIMIT enabled cycles from reset release to done=1.

Decomposition:
- Package dcl_pkg holds:
  - state enum {RUN, DONE}.
  - Default constants mirroring the parameters.
  - A function computing the expected final y for prop_ok.
- One natural sub-module, dcl_step: combinational next-x / next-y / sat-flag calculation from (x, y, knee, limit). The top owns state, config latches and handshake.

Test Plan:
- Default run: release reset, selector=1 for 200 cycles -> x=200, y=200, done=1, prop_ok=1; cycle 100 shows x=100, y=100; cycle 101 shows x=101, y=101.
- Enable gating: selector alternating 1/0 from reset -> x=200, done=1 after 400 cycles; x and y are unchanged on every selector=0 cycle.
- Reload in DONE: cfg limit=10, knee=4, y_init=5 -> cfg_ready drops next cycle; after 10 enabled cycles x=10, y=11, done=1, prop_ok=1. A cfg_valid pulse mid-run is ignored.
- Saturation: cfg limit=50, knee=0, y_init=2040 -> y reaches 2047 after 7 steps and holds; y_sat=1, done at x=50, prop_ok=1.
- Edge configs:
  - limit=0 -> done one enabled cycle after load, x=0, y=y_init.
  - knee>=limit (e.g. limit=8, knee=20) -> y unchanged, prop_ok=1.
- Reset mid-run at x=57 -> next cycle x=0, y=100, done=0, defaults restored, and a full default run completes as in the first scenario.
